iir_sample_feeder: RTL and testbench

Upstream stage of the folded 2-tap IIR filter. Accepts input samples over a valid/ready stream, buffers them in a small FIFO, and presents one sample per two-cycle fold period on the filter's `x` input. It also generates the fold-phase select `clkm` that drives the filter's time-multiplexers and output capture. Starved fold periods are filled with zero and counted, because the filter's delay chain is free-running and cannot stall.

---
 rtl/iir_sample_feeder.sv | 134 +++++++++++++
 tb/tb_iir_sample_feeder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_sample_feeder.sv
// Upstream feeder for the folded 2-tap IIR filter: buffers stream samples in a
// small FIFO and presents one sample per two-cycle fold period with its phase select.
module iir_sample_feeder #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [N-1:0]             in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N-1:0]             x,
    output logic                     clkm,
    output logic                     x_valid,
    output logic                     underrun,
    output logic [7:0]               underrun_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic load_c;
    logic empty_c;
    logic push_c;
    logic pop_c;

    // in_ready depends on level only, so a same-edge pop never admits a push into a full FIFO
    assign in_ready = (level < LW'(DEPTH));
    assign empty_c  = (level == '0);
    assign push_c   = in_valid && in_ready;
    // A load happens on every edge that enters PH0; run is only consulted here
    assign load_c   = run && ((state == IDLE) || (state == PH1));
    assign pop_c    = load_c && !empty_c;

    // Sample storage; no reset needed since level gates every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Fold-phase sequencer with registered x/clkm/x_valid/underrun outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            clkm         <= 1'b0;
            x            <= '0;
            x_valid      <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= PH0;
                        clkm  <= 1'b1;
                    end
                end
                PH0: begin
                    state <= PH1;
                    clkm  <= 1'b0;
                end
                PH1: begin
                    if (run) begin
                        state <= PH0;
                        clkm  <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        clkm    <= 1'b0;
                        x       <= '0;
                        x_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clkm    <= 1'b0;
                    x       <= '0;
                    x_valid <= 1'b0;
                end
            endcase

            // An empty FIFO at load time yields a zero filler, since the filter cannot stall
            if (load_c) begin
                if (!empty_c) begin
                    x       <= mem[rd_ptr];
                    x_valid <= 1'b1;
                end else begin
                    x        <= '0;
                    x_valid  <= 1'b0;
                    underrun <= 1'b1;
                    if (underrun_cnt != 8'hFF) begin
                        underrun_cnt <= underrun_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_iir_sample_feeder.sv
// Directed self-checking bench for iir_sample_feeder (N=16, DEPTH=4).
module tb_iir_sample_feeder;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic        clkm;
    logic        x_valid;
    logic        underrun;
    logic [7:0]  underrun_cnt;
    logic [2:0]  level;

    int tests = 0;
    int fails = 0;

    iir_sample_feeder #(.N(16), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .x            (x),
        .clkm         (clkm),
        .x_valid      (x_valid),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push_idle(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_power_on();
        do_reset();
        tests++;
        if ({clkm, x_valid, underrun} !== 3'b000 || x !== 16'h0 || level !== 3'd0 ||
            underrun_cnt !== 8'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL power_on: clkm=%b xv=%b ur=%b x=%h lvl=%0d cnt=%0d rdy=%b want all 0, rdy=1",
                     clkm, x_valid, underrun, x, level, underrun_cnt, in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        push_idle(16'h0123);          // edge 0
        step();                       // edge 1
        tests++;
        if (level !== 3'd1 || clkm !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: lvl=%0d clkm=%b want 1 0", level, clkm);
        end
        run = 1'b1;
        step();                       // edge 2
        tests++;
        if (clkm !== 1'b1 || x !== 16'h0123 || x_valid !== 1'b1 || level !== 3'd0) begin
            fails++;
            $display("FAIL single_load: clkm=%b x=%h xv=%b lvl=%0d want 1 0123 1 0", clkm, x, x_valid, level);
        end
        step();                       // edge 3
        tests++;
        if (clkm !== 1'b0 || x !== 16'h0123 || x_valid !== 1'b1) begin
            fails++;
            $display("FAIL single_ph1: clkm=%b x=%h xv=%b want 0 0123 1", clkm, x, x_valid);
        end
        step();                       // edge 4
        tests++;
        if (underrun !== 1'b1 || x !== 16'h0 || x_valid !== 1'b0 || underrun_cnt !== 8'd1 || clkm !== 1'b1) begin
            fails++;
            $display("FAIL single_underrun: ur=%b x=%h xv=%b cnt=%0d clkm=%b want 1 0000 0 1 1",
                     underrun, x, x_valid, underrun_cnt, clkm);
        end
        run = 1'b0;
        step();
        tests++;
        if (underrun !== 1'b0) begin
            fails++;
            $display("FAIL single_pulse_width: ur=%b want 0", underrun);
        end
        step();
    endtask

    task automatic test_streaming();
        logic        rdy;
        logic        v;
        logic        saw_full;
        int          k;
        logic [15:0] exp_x;
        do_reset();
        saw_full = 1'b0;
        k = 1;
        in_valid = 1'b1;
        in_data  = 16'd1;
        step();                       // sample 1 accepted while idle
        k = 2;
        in_data = 16'd2;
        run = 1'b1;
        for (int c = 0; c < 16; c++) begin
            rdy = in_ready;
            v   = in_valid;
            if (!rdy) saw_full = 1'b1;
            step();
            if (v && rdy) k++;
            in_valid = (k <= 8);
            in_data  = 16'(k);
            exp_x = 16'(c / 2 + 1);
            tests++;
            if (x !== exp_x || clkm !== ((c % 2) == 0) || underrun !== 1'b0 || x_valid !== 1'b1) begin
                fails++;
                $display("FAIL stream_c%0d: x=%0d clkm=%b ur=%b xv=%b want x=%0d clkm=%b ur=0 xv=1",
                         c, x, clkm, underrun, x_valid, exp_x, (c % 2) == 0);
            end
        end
        tests++;
        if (k !== 9 || saw_full !== 1'b1 || level !== 3'd0) begin
            fails++;
            $display("FAIL stream_accept: accepted_next=%0d saw_full=%b lvl=%0d want 9 1 0", k, saw_full, level);
        end
        step();
        tests++;
        if (underrun !== 1'b1 || x !== 16'h0 || clkm !== 1'b1) begin
            fails++;
            $display("FAIL stream_drain: ur=%b x=%h clkm=%b want 1 0000 1", underrun, x, clkm);
        end
        run = 1'b0;
        step();
        step();
    endtask

    task automatic test_full_pop();
        do_reset();
        push_idle(16'hA001);
        push_idle(16'hA002);
        push_idle(16'hA003);
        push_idle(16'hA004);
        tests++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL full_level: lvl=%0d rdy=%b want 4 0", level, in_ready);
        end
        in_valid = 1'b1;
        in_data  = 16'h0055;
        run = 1'b1;
        step();
        tests++;
        if (level !== 3'd3 || x !== 16'hA001 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_pop: lvl=%0d x=%h rdy=%b want 3 a001 1", level, x, in_ready);
        end
        run = 1'b0;
        step();
        in_valid = 1'b0;
        tests++;
        if (level !== 3'd4 || clkm !== 1'b0) begin
            fails++;
            $display("FAIL full_push_next: lvl=%0d clkm=%b want 4 0", level, clkm);
        end
        step();
    endtask

    task automatic test_stop_mid();
        do_reset();
        push_idle(16'hBEEF);
        push_idle(16'hCAFE);
        run = 1'b1;
        step();
        run = 1'b0;                   // dropped during PH0
        tests++;
        if (clkm !== 1'b1 || x !== 16'hBEEF || level !== 3'd1) begin
            fails++;
            $display("FAIL stop_ph0: clkm=%b x=%h lvl=%0d want 1 beef 1", clkm, x, level);
        end
        step();
        tests++;
        if (clkm !== 1'b0 || x !== 16'hBEEF || x_valid !== 1'b1) begin
            fails++;
            $display("FAIL stop_ph1: clkm=%b x=%h xv=%b want 0 beef 1", clkm, x, x_valid);
        end
        step();
        tests++;
        if (clkm !== 1'b0 || x !== 16'h0 || x_valid !== 1'b0 || level !== 3'd1) begin
            fails++;
            $display("FAIL stop_idle: clkm=%b x=%h xv=%b lvl=%0d want 0 0000 0 1", clkm, x, x_valid, level);
        end
        step();
        run = 1'b1;
        step();
        tests++;
        if (clkm !== 1'b1 || x !== 16'hCAFE || x_valid !== 1'b1 || level !== 3'd0 || underrun !== 1'b0) begin
            fails++;
            $display("FAIL stop_resume: clkm=%b x=%h xv=%b lvl=%0d ur=%b want 1 cafe 1 0 0",
                     clkm, x, x_valid, level, underrun);
        end
        run = 1'b0;
        step();
        step();
    endtask

    task automatic test_saturation();
        int pulses;
        int x_bad;
        do_reset();
        pulses = 0;
        x_bad = 0;
        run = 1'b1;
        for (int c = 0; c < 600; c++) begin
            step();
            if (underrun === 1'b1) pulses++;
            if (x !== 16'h0 || x_valid !== 1'b0) x_bad++;
        end
        tests++;
        if (pulses !== 300) begin
            fails++;
            $display("FAIL sat_pulses: got %0d want 300", pulses);
        end
        tests++;
        if (underrun_cnt !== 8'd255) begin
            fails++;
            $display("FAIL sat_count: got %0d want 255", underrun_cnt);
        end
        tests++;
        if (x_bad !== 0) begin
            fails++;
            $display("FAIL sat_x_zero: nonzero x cycles %0d want 0", x_bad);
        end
        run = 1'b0;
        step();
        step();
    endtask

    // Runs straight after saturation so underrun_cnt is nonzero going in
    task automatic test_reset();
        push_idle(16'h0011);
        push_idle(16'h0022);
        push_idle(16'h0033);
        push_idle(16'h0044);
        run = 1'b1;
        step();
        tests++;
        if (clkm !== 1'b1 || level !== 3'd3 || underrun_cnt !== 8'd255) begin
            fails++;
            $display("FAIL rst_setup: clkm=%b lvl=%0d cnt=%0d want 1 3 255", clkm, level, underrun_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (clkm !== 1'b0 || x !== 16'h0 || x_valid !== 1'b0 || level !== 3'd0 ||
            underrun_cnt !== 8'd0 || in_ready !== 1'b1 || underrun !== 1'b0) begin
            fails++;
            $display("FAIL rst_async: clkm=%b x=%h xv=%b lvl=%0d cnt=%0d rdy=%b ur=%b want 0 0000 0 0 0 1 0",
                     clkm, x, x_valid, level, underrun_cnt, in_ready, underrun);
        end
        run = 1'b0;
        #2;
        rst = 1'b0;
        step();
        step();
        step();
        tests++;
        if (clkm !== 1'b0 || x !== 16'h0 || level !== 3'd0 || underrun_cnt !== 8'd0 || underrun !== 1'b0) begin
            fails++;
            $display("FAIL rst_idle_after: clkm=%b x=%h lvl=%0d cnt=%0d ur=%b want 0 0000 0 0 0",
                     clkm, x, level, underrun_cnt, underrun);
        end
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        test_power_on();
        test_single();
        test_streaming();
        test_full_pop();
        test_stop_mid();
        test_saturation();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
